route_cmd_proc: RTL

Parametrised command processor for the follower vehicle. It replaces the single-destination command handler with a destination queue of configurable depth and ID width, adds pause/resume and go-now (flush-and-replace) commands, and uses a configurable buzzer period. It sits between the command UART receiver (`cmd_rdy`/`cmd`), the station-ID receiver (`id_vld`/`id`) and the motion/obstacle logic (`ok2move`). Its outputs are `go`, the piezo drive and transit status.

---
 rtl/route_cmd_proc.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/route_cmd_proc.sv
// Follower-vehicle command processor: a circular destination queue driven by
// UART commands and station IDs, plus a transit/pause FSM and a piezo buzzer.
module route_cmd_proc #(
    parameter int ID_W      = 6,
    parameter int DEPTH     = 4,
    parameter int BUZZ_HALF = 62500
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_rdy,
    input  logic [ID_W+1:0]          cmd,
    output logic                     clr_cmd_rdy,
    input  logic                     id_vld,
    input  logic [ID_W+1:0]          id,
    output logic                     clr_id_vld,
    input  logic                     ok2move,
    output logic                     go,
    output logic                     buzz,
    output logic                     buzz_n,
    output logic                     in_transit,
    output logic [ID_W-1:0]          dest_id,
    output logic [$clog2(DEPTH):0]   q_cnt,
    output logic                     arrived,
    output logic                     q_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(BUZZ_HALF);

    localparam logic [1:0] OP_STOP   = 2'b00;
    localparam logic [1:0] OP_GO     = 2'b01;
    localparam logic [1:0] OP_GO_NOW = 2'b10;
    localparam logic [1:0] OP_PAUSE  = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRANSIT = 2'd1,
        PAUSED  = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              cmd_pend_reg, id_pend_reg;
    logic              arrived_reg, q_ovf_reg;
    logic [BW-1:0]     buzz_cnt_reg;
    logic              buzz_reg;

    logic              cmd_acc, id_acc, id_match, ovf;
    logic              wr_en;
    logic [PW-1:0]     wr_addr;
    logic [ID_W-1:0]   wr_data;
    logic [1:0]        cmd_op;
    logic [ID_W-1:0]   head;
    logic              buzz_en;
    logic [ID_W-1:0]   slots [DEPTH];

    // Accept handshakes: a held request is consumed once; nothing is accepted in reset.
    assign cmd_acc     = cmd_rdy & ~cmd_pend_reg & ~rst;
    assign id_acc      = id_vld & ~id_pend_reg & ~rst;
    assign clr_cmd_rdy = cmd_acc;
    assign clr_id_vld  = id_acc;

    assign cmd_op  = cmd[ID_W+1:ID_W];
    assign head    = slots[rd_ptr_reg];
    assign dest_id = (cnt_reg == '0) ? '0 : head;

    assign id_match = id_acc && (state_reg == TRANSIT) && (id[ID_W+1:ID_W] == 2'b00)
                      && (id[ID_W-1:0] == dest_id) && (cnt_reg != '0);

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            logic [ID_W-1:0] slot_reg;
            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == PW'(gi))) begin
                    slot_reg <= wr_data;
                end
            end
            assign slots[gi] = slot_reg;
        end
    endgenerate

    // The ID pop is applied first; the command then acts on the popped result.
    always_comb begin
        state_next  = state_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        cnt_next    = cnt_reg;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr_reg;
        wr_data     = cmd[ID_W-1:0];
        ovf         = 1'b0;

        if (id_match) begin
            rd_ptr_next = rd_ptr_reg + PW'(1);
            cnt_next    = cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
                state_next = IDLE;
            end
        end

        if (cmd_acc) begin
            case (cmd_op)
                OP_STOP: begin
                    rd_ptr_next = '0;
                    wr_ptr_next = '0;
                    cnt_next    = '0;
                    state_next  = IDLE;
                end
                OP_GO: begin
                    if (cnt_next == CW'(DEPTH)) begin
                        ovf = 1'b1;
                    end else begin
                        wr_en       = 1'b1;
                        wr_addr     = wr_ptr_reg;
                        wr_ptr_next = wr_ptr_reg + PW'(1);
                        cnt_next    = cnt_next + CW'(1);
                        if (state_next == IDLE) begin
                            state_next = TRANSIT;
                        end
                    end
                end
                OP_GO_NOW: begin
                    wr_en       = 1'b1;
                    wr_addr     = '0;
                    rd_ptr_next = '0;
                    wr_ptr_next = PW'(1);
                    cnt_next    = CW'(1);
                    if (state_next == IDLE) begin
                        state_next = TRANSIT;
                    end
                end
                OP_PAUSE: begin
                    if (state_next == TRANSIT) begin
                        state_next = PAUSED;
                    end else if (state_next == PAUSED) begin
                        state_next = TRANSIT;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            cnt_reg      <= '0;
            cmd_pend_reg <= 1'b0;
            id_pend_reg  <= 1'b0;
            arrived_reg  <= 1'b0;
            q_ovf_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
            cnt_reg      <= cnt_next;
            cmd_pend_reg <= cmd_rdy ? (cmd_pend_reg | cmd_acc) : 1'b0;
            id_pend_reg  <= id_vld ? (id_pend_reg | id_acc) : 1'b0;
            arrived_reg  <= id_match;
            q_ovf_reg    <= ovf;
        end
    end

    assign in_transit = (state_reg == TRANSIT);
    assign go         = in_transit & ok2move;
    assign buzz_en    = in_transit & ~ok2move;

    // Half-period counter; first edge lands BUZZ_HALF cycles after enable.
    always_ff @(posedge clk) begin
        if (rst || !buzz_en) begin
            buzz_cnt_reg <= '0;
            buzz_reg     <= 1'b0;
        end else if (buzz_cnt_reg == BW'(BUZZ_HALF - 1)) begin
            buzz_cnt_reg <= '0;
            buzz_reg     <= ~buzz_reg;
        end else begin
            buzz_cnt_reg <= buzz_cnt_reg + BW'(1);
        end
    end

    assign buzz    = buzz_reg;
    assign buzz_n  = ~buzz_reg;
    assign q_cnt   = cnt_reg;
    assign arrived = arrived_reg;
    assign q_ovf   = q_ovf_reg;

endmodule
